trng_conditioner: RTL and testbench
===================================

# trng_conditioner

Post-processing stage that sits directly downstream of the tinytrng entropy source. It consumes the raw one-bit-per-sample stream and removes bias with a von Neumann corrector. It packs the corrected bits into bytes and buffers them in a small FIFO behind a valid/ready interface. A repetition-count health test runs on the raw stream and blocks all output when the source appears stuck.

## Interface
- RCT_LIMIT, 32: consecutive identical raw bits that trip the health test (range 2..255).
- FIFO_DEPTH, 4: output FIFO depth in bytes (power of two, 2..16).
- clk  in  1  system clock, same domain as the entropy source sampling.
- resetn  in  1  reset, synchronous, active-low.
- raw_bit  in  1  raw entropy bit (source `random` output).
- raw_valid  in  1  single-cycle strobe, raw_bit sampled when high; may be high on consecutive cycles.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently stored.
- health_fail  out  1  sticky repetition-count failure.
- overflow  out  1  sticky, byte dropped because FIFO was full.
- clear_fail  in  1  single-cycle, clears health_fail, overflow and the health/pair/packer state.

## Operation
- Reset values: out_data 0, out_valid 0, fifo_level 0, health_fail 0, overflow 0. Internal state: pair hold empty, packer count 0, RCT count 0, FIFO pointers 0.
- The repetition-count test (RCT) evaluates every raw_valid.
  - First bit after reset or clear: count = 1.
  - Bit equal to the previous bit: count + 1, saturating at RCT_LIMIT.
  - Bit different from the previous bit: count = 1.
  - When the updated count equals RCT_LIMIT, health_fail sets on that same edge. The triggering bit is not passed to the pair stage.
- Pair stage (von Neumann) runs only while health_fail = 0.
  - If no bit is held, the incoming bit is held.
  - If a bit is held, the hold is released. Pair (a,b) with a≠b emits a. Pairs 00 and 11 emit nothing.
- Packer: shift register sr <= {sr[6:0], bit} per emitted bit, with a 3-bit count. The first bit of a byte ends in out_data[7].
  - On the 8th bit, {sr[6:0], bit} is pushed into the FIFO on the same edge and count wraps to 0.
- FIFO is first-word fall-through.
  - Pop occurs when out_valid & out_ready.
  - A push when full is accepted only if a pop happens on the same cycle. Otherwise the byte is dropped and overflow sets.
  - A push and a pop on the same cycle when not full leaves fifo_level unchanged.
  - When empty, out_data holds its last value; it is 0 after reset.
- Health failure: on the edge health_fail sets, the FIFO is flushed (level 0, out_valid 0), the pair hold is cleared and the packer count is cleared. While health_fail = 1, raw bits update only the RCT count; nothing is pushed.
- clear_fail clears the following on the next edge: health_fail, overflow, RCT count (the next bit counts as the first), pair hold and packer count. FIFO contents are kept.
  - If clear_fail and a raw_valid arrive on the same cycle, clear wins and that raw bit is discarded.
- resetn low has priority over everything and aborts any partial pair or byte.

## Timing
- raw_valid edge to RCT, pair, packer and FIFO update: 1 clock.
- Push edge to out_valid high: visible the cycle after the edge that completes the byte.
- Pop: out_data and out_valid reflect the next entry the cycle after the accepting edge.
- health_fail rises 1 cycle after the raw_valid carrying the RCT_LIMIT-th identical bit. out_valid falls on the same edge.
- Throughput: at most 1 byte per 16 raw_valid strobes; no bubbles are inserted by the block itself.
- out_data is stable while out_valid & !out_ready.

## Test plan
- Reset: hold resetn low 3 cycles with random inputs -> all outputs 0, fifo_level 0.
- Debias: raw pairs (0,1),(1,0) repeated 4 times (16 strobes), out_ready=1 -> one byte 0x55, out_valid high 1 cycle after the 16th strobe.
- Discard: 16 strobes of pairs 00,11,00,11,… -> no out_valid, fifo_level 0, health_fail 0.
- Backpressure/overflow: out_ready=0, FIFO_DEPTH=4, feed 5 bytes (0x01..0x05 patterns) -> fifo_level 4, overflow=1. Draining gives 0x01..0x04 in order. A fifth-byte push coincident with a pop at full is accepted with no overflow.
- Health: 31 ones then a zero -> health_fail 0. 32 consecutive ones -> health_fail=1 one cycle later, FIFO flushed, further bytes ignored. Pulse clear_fail, then 16 valid strobes -> byte delivered normally.
- Mid-operation: assert resetn low after 5 debiased bits, then send 8 debiased bits -> exactly one byte equal to those 8 bits.

Source files
------------

// File: rtl/trng_conditioner_if.sv
// Raw entropy input and byte-stream output handshake of the TRNG conditioner.
// The slave side is the conditioner; the master side drives entropy and consumes bytes.
interface trng_conditioner_if;
   logic       raw_bit;
   logic       raw_valid;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output raw_bit, raw_valid, out_ready, input out_data, out_valid);
   modport slave  (input raw_bit, raw_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/trng_conditioner.sv
// Von Neumann debiaser, byte packer and FWFT output FIFO behind a repetition-count
// health test on the raw entropy stream.
module trng_conditioner #(
   parameter int RCT_LIMIT  = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   trng_conditioner_if.slave             bus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          health_fail,
   output logic                          overflow,
   input  logic                          clear_fail
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [7:0]    LIMIT = 8'(RCT_LIMIT);
   localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

   logic          have_prev;
   logic          prev_bit;
   logic [7:0]    rct_cnt;
   logic [7:0]    rct_next;
   logic          hold_valid;
   logic          hold_bit;
   logic [6:0]    sr;
   logic [2:0]    pk_cnt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    last_data;

   logic sample;
   logic trip;
   logic pair_en;
   logic emit;
   logic push;
   logic pop;
   logic full;
   logic push_ok;
   logic drop;
   logic [7:0] push_byte;

   // A strobe coinciding with clear_fail is discarded; a tripping bit never reaches the pair stage.
   always_comb begin
      sample = bus.raw_valid & ~clear_fail;
      if (!have_prev)
         rct_next = 8'd1;
      else if (bus.raw_bit == prev_bit)
         rct_next = (rct_cnt == LIMIT) ? LIMIT : rct_cnt + 8'd1;
      else
         rct_next = 8'd1;
      trip      = sample & ~health_fail & (rct_next == LIMIT);
      pair_en   = sample & ~health_fail & ~trip;
      emit      = pair_en & hold_valid & (hold_bit != bus.raw_bit);
      push      = emit & (pk_cnt == 3'd7);
      push_byte = {sr, hold_bit};
      pop       = bus.out_valid & bus.out_ready;
      full      = (fifo_level == DEPTH);
      push_ok   = push & (~full | pop);
      drop      = push & full & ~pop;
   end

   assign bus.out_valid = (fifo_level != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : last_data;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         have_prev   <= 1'b0;
         prev_bit    <= 1'b0;
         rct_cnt     <= 8'd0;
         health_fail <= 1'b0;
         overflow    <= 1'b0;
      end else if (clear_fail) begin
         have_prev   <= 1'b0;
         rct_cnt     <= 8'd0;
         health_fail <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (bus.raw_valid) begin
            have_prev <= 1'b1;
            prev_bit  <= bus.raw_bit;
            rct_cnt   <= rct_next;
         end
         if (trip)
            health_fail <= 1'b1;
         if (drop)
            overflow <= 1'b1;
      end
   end

   // The held bit is the first of a pair; the packer keeps the 7 most recent corrected bits.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hold_valid <= 1'b0;
         hold_bit   <= 1'b0;
         sr         <= 7'd0;
         pk_cnt     <= 3'd0;
      end else if (clear_fail || trip) begin
         hold_valid <= 1'b0;
         pk_cnt     <= 3'd0;
      end else begin
         if (pair_en) begin
            if (hold_valid) begin
               hold_valid <= 1'b0;
            end else begin
               hold_valid <= 1'b1;
               hold_bit   <= bus.raw_bit;
            end
         end
         if (emit) begin
            sr     <= {sr[5:0], hold_bit};
            pk_cnt <= pk_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_byte;
   end

   // last_data tracks the displayed head so out_data holds its value once the FIFO drains.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         last_data  <= 8'd0;
      end else begin
         if (bus.out_valid)
            last_data <= bus.out_data;
         if (trip) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
               2'b10:   fifo_level <= fifo_level + LW'(1);
               2'b01:   fifo_level <= fifo_level - LW'(1);
               default: fifo_level <= fifo_level;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trng_conditioner.sv
// Scoreboard bench for trng_conditioner: directed raw-bit vectors push expected bytes,
// a negedge monitor compares every accepted output byte.
module tb_trng_conditioner;

   localparam int FIFO_DEPTH = 4;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          clk;
   logic          resetn;
   logic          clear_fail;
   logic [LW-1:0] fifo_level;
   logic          health_fail;
   logic          overflow;

   trng_conditioner_if bus ();

   trng_conditioner #(.RCT_LIMIT(32), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus.slave),
      .fifo_level  (fifo_level),
      .health_fail (health_fail),
      .overflow    (overflow),
      .clear_fail  (clear_fail)
   );

   int total = 0;
   int bad   = 0;
   logic [7:0] expq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every byte the consumer accepts must be the oldest expected one.
   always @(negedge clk) begin
      if (resetn && bus.out_valid && bus.out_ready) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_byte: got %02h, required none", bus.out_data);
         end else begin
            logic [7:0] e;
            e = expq.pop_front();
            if (bus.out_data !== e) begin
               bad++;
               $display("[TB] FAIL byte_order: got %02h, required %02h", bus.out_data, e);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic b);
      bus.raw_bit   = b;
      bus.raw_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.raw_valid = 1'b0;
   endtask

   task automatic sendPairBit(input logic b);
      applyStimulus(b);
      applyStimulus(~b);
   endtask

   task automatic sendByte(input logic [7:0] v, input bit expect_it);
      if (expect_it)
         expq.push_back(v);
      for (int i = 7; i >= 0; i--)
         sendPairBit(v[i]);
   endtask

   task automatic pulseClear();
      clear_fail = 1'b1;
      @(posedge clk);
      #1;
      clear_fail = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 100 && expq.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput(name, expq.size(), 0);
   endtask

   initial begin
      resetn        = 1'b0;
      clear_fail    = 1'b0;
      bus.raw_bit   = 1'b0;
      bus.raw_valid = 1'b0;
      bus.out_ready = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         bus.raw_bit   = 1'($urandom_range(0, 1));
         bus.raw_valid = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         clear_fail    = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_data", bus.out_data, 0);
      checkOutput("rst_level", fifo_level, 0);
      checkOutput("rst_health", health_fail, 0);
      checkOutput("rst_overflow", overflow, 0);
      bus.raw_valid = 1'b0;
      bus.out_ready = 1'b0;
      clear_fail    = 1'b0;
      resetn        = 1'b1;
      @(posedge clk);
      #1;

      // Debias: 0x55 from pairs (0,1),(1,0)
      bus.out_ready = 1'b1;
      sendByte(8'h55, 1'b1);
      checkOutput("debias_valid", bus.out_valid, 1);
      checkOutput("debias_data", bus.out_data, 8'h55);
      waitDrain("debias_drain");
      checkOutput("debias_hold_data", bus.out_data, 8'h55);

      // Discard: equal pairs produce nothing
      for (int i = 0; i < 8; i++) begin
         applyStimulus(i[0]);
         applyStimulus(i[0]);
      end
      checkOutput("discard_valid", bus.out_valid, 0);
      checkOutput("discard_level", fifo_level, 0);
      checkOutput("discard_health", health_fail, 0);

      // Backpressure and overflow
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++)
         sendByte(8'(i), i <= 4);
      checkOutput("ovf_level", fifo_level, 4);
      checkOutput("ovf_flag", overflow, 1);
      checkOutput("ovf_head_stable", bus.out_data, 8'h01);
      bus.out_ready = 1'b1;
      waitDrain("ovf_drain");
      pulseClear();
      checkOutput("ovf_cleared", overflow, 0);

      // Push at full coincident with a pop is accepted
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         sendByte(8'h11 + 8'(i), 1'b1);
      checkOutput("full_level", fifo_level, 4);
      expq.push_back(8'h15);
      for (int i = 7; i >= 1; i--)
         sendPairBit(1'(8'h15 >> i));
      applyStimulus(1'b1);
      bus.out_ready = 1'b1;
      applyStimulus(1'b0);
      bus.out_ready = 1'b0;
      checkOutput("full_pushpop_level", fifo_level, 4);
      checkOutput("full_pushpop_ovf", overflow, 0);
      bus.out_ready = 1'b1;
      waitDrain("full_drain");

      // Health: 31 ones then a zero does not trip
      pulseClear();
      for (int i = 0; i < 31; i++)
         applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("rct31_health", health_fail, 0);
      pulseClear();

      // 32 ones trip the test and flush the FIFO
      bus.out_ready = 1'b0;
      sendByte(8'hA5, 1'b0);
      pulseClear();
      for (int i = 0; i < 31; i++)
         applyStimulus(1'b1);
      checkOutput("rct_pre_health", health_fail, 0);
      checkOutput("rct_pre_level", fifo_level, 1);
      applyStimulus(1'b1);
      checkOutput("rct_trip_health", health_fail, 1);
      checkOutput("rct_flush_level", fifo_level, 0);
      checkOutput("rct_flush_valid", bus.out_valid, 0);
      sendByte(8'h3C, 1'b0);
      checkOutput("rct_blocked_level", fifo_level, 0);
      checkOutput("rct_sticky", health_fail, 1);
      bus.out_ready = 1'b1;
      pulseClear();
      checkOutput("rct_cleared", health_fail, 0);
      sendByte(8'h96, 1'b1);
      waitDrain("rct_recover_drain");

      // Mid-operation reset aborts a partial byte
      for (int i = 0; i < 5; i++)
         sendPairBit(i[0]);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      checkOutput("midrst_level", fifo_level, 0);
      sendByte(8'hC3, 1'b1);
      waitDrain("midrst_drain");
      repeat (5) @(posedge clk);
      #1;
      checkOutput("final_level", fifo_level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
